// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
// Receive-side frame sequencer. Arms the rx datapath, follows its event
// stream, guards against stalled frames with a watchdog, and streams a
// good-FCS frame out of the rx buffer as valid/ready bytes. Bad-FCS and
// stalled frames are dropped and counted.
//
// Buffer reads are pipelined one entry ahead: while a byte waits in SEND,
// o_buf_r_addr already points at the next entry. The buffer's one-cycle
// read latency is therefore hidden, and a single FETCH cycle can capture
// the next byte. With i_ready held high this gives one byte every 2 cycles.
module rx_frame_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int unsigned RECOVER_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_arm,
  output logic       o_rx_enable,
  input  logic [2:0] i_rx_ev,
  input  logic       i_rx_ev_sig,
  input  logic       i_rx_fcs_ok,
  output logic [6:0] o_buf_r_addr,
  input  logic [7:0] i_buf_r_byte,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_busy,
  output logic       o_timeout,
  output logic [7:0] o_drop_cnt
);

  // rx event codes: PREAMBLE=0, SFD=1, PHR=2, BYTE=3, END=4.
  // PREAMBLE and BYTE need no action here, so only these three are decoded.
  localparam logic [2:0] RX_EVENT_SFD = 3'd1;
  localparam logic [2:0] RX_EVENT_PHR = 3'd2;
  localparam logic [2:0] RX_EVENT_END = 3'd4;

  localparam int unsigned RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [RC_W-1:0] REC_LAST = RC_W'(RECOVER_CYC - 1);
  localparam logic [15:0] WD_LAST = TIMEOUT_CYC - 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LISTEN  = 3'd1,
    ST_RECV    = 3'd2,
    ST_FETCH   = 3'd3,
    ST_SEND    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [15:0]     wd_r;
  logic [RC_W-1:0] rec_cnt_r;
  logic [6:0]      len_r;
  logic            phr_pend_r;
  logic            ev_sfd_s;
  logic            ev_phr_s;
  logic            ev_end_s;
  logic            wd_hit_s;
  logic            hs_s;
  logic            drop_s;
  logic            abort_s;

  // The PHR length byte is clamped so that the 7-bit read pointer never wraps.
  function automatic logic [6:0] clamp_len(input logic [7:0] b);
    if (b[7]) begin
      clamp_len = 7'h7F;
    end else begin
      clamp_len = b[6:0];
    end
  endfunction

  assign ev_sfd_s = i_rx_ev_sig & (i_rx_ev == RX_EVENT_SFD);
  assign ev_phr_s = i_rx_ev_sig & (i_rx_ev == RX_EVENT_PHR);
  assign ev_end_s = i_rx_ev_sig & (i_rx_ev == RX_EVENT_END);
  assign wd_hit_s = (wd_r == WD_LAST);
  assign hs_s     = o_valid & i_ready;

  // Next-state logic, plus drop and abort strobes for the current cycle
  always_comb begin
    state_s = state_r;
    drop_s  = 1'b0;
    abort_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_arm) begin
          state_s = ST_LISTEN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LISTEN: begin
        if (!i_arm) begin
          state_s = ST_IDLE;
        end else if (ev_sfd_s) begin
          state_s = ST_RECV;
        end else begin
          state_s = ST_LISTEN;
        end
      end
      ST_RECV: begin
        if (!i_arm) begin
          state_s = ST_IDLE;
        end else if (ev_end_s) begin
          if (i_rx_fcs_ok) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_RECOVER;
            drop_s  = 1'b1;
          end
        end else if (wd_hit_s) begin
          state_s = ST_RECOVER;
          drop_s  = 1'b1;
          abort_s = 1'b1;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_FETCH: begin
        state_s = ST_SEND;
      end
      ST_SEND: begin
        if (hs_s) begin
          if (o_last) begin
            if (i_arm) begin
              state_s = ST_RECOVER;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_RECOVER: begin
        if (rec_cnt_r == REC_LAST) begin
          if (i_arm) begin
            state_s = ST_LISTEN;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_RECOVER;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status outputs, registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rx_enable <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_drop_cnt  <= 8'd0;
    end else begin
      o_rx_enable <= (state_s == ST_LISTEN) || (state_s == ST_RECV);
      o_busy      <= (state_s != ST_IDLE);
      o_timeout   <= abort_s;
      if (drop_s && (o_drop_cnt != 8'hFF)) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

  // Inter-event watchdog in RECV and the RECOVER dwell counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_r      <= 16'd0;
      rec_cnt_r <= '0;
    end else begin
      if ((state_r == ST_RECV) && !i_rx_ev_sig) begin
        wd_r <= wd_r + 16'd1;
      end else begin
        wd_r <= 16'd0;
      end
      if (state_r == ST_RECOVER) begin
        rec_cnt_r <= rec_cnt_r + RC_W'(1);
      end else begin
        rec_cnt_r <= '0;
      end
    end
  end

  // Frame length: one cycle after PHR, buffer entry 0 holds the length byte
  always_ff @(posedge clk) begin
    if (reset) begin
      phr_pend_r <= 1'b0;
      len_r      <= 7'd0;
    end else begin
      phr_pend_r <= (state_r == ST_RECV) && ev_phr_s;
      if (state_r == ST_LISTEN) begin
        len_r <= 7'd0;
      end else if (phr_pend_r) begin
        len_r <= clamp_len(i_buf_r_byte);
      end
    end
  end

  // Buffer read pointer: held at 0 until the frame is fetched, then one entry ahead
  always_ff @(posedge clk) begin
    if (reset) begin
      o_buf_r_addr <= 7'd0;
    end else if ((state_r == ST_IDLE) || (state_r == ST_LISTEN) || (state_r == ST_RECOVER)) begin
      o_buf_r_addr <= 7'd0;
    end else if ((state_r == ST_FETCH) && (o_buf_r_addr != len_r)) begin
      o_buf_r_addr <= o_buf_r_addr + 7'd1;
    end
  end

  // Host-side output stage: capture in FETCH, hold through SEND until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data  <= 8'd0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (state_r == ST_FETCH) begin
      o_data  <= i_buf_r_byte;
      o_valid <= 1'b1;
      o_last  <= (o_buf_r_addr == len_r);
    end else if ((state_r == ST_SEND) && hs_s) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl
// Random and directed frames for rx_frame_ctrl. The stimulus side pushes the
// expected host byte stream into a queue. A negedge monitor pops the queue and
// compares whenever a valid/ready handshake occurs.
module tb_rx_frame_ctrl;

  localparam logic [15:0] TMO = 16'd40;
  localparam int          REC = 4;
  localparam logic [2:0]  EV_PRE  = 3'd0;
  localparam logic [2:0]  EV_SFD  = 3'd1;
  localparam logic [2:0]  EV_PHR  = 3'd2;
  localparam logic [2:0]  EV_BYTE = 3'd3;
  localparam logic [2:0]  EV_END  = 3'd4;

  logic       clk;
  logic       reset;
  logic       i_arm;
  logic       o_rx_enable;
  logic [2:0] i_rx_ev;
  logic       i_rx_ev_sig;
  logic       i_rx_fcs_ok;
  logic [6:0] o_buf_r_addr;
  logic [7:0] i_buf_r_byte;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_last;
  logic       o_busy;
  logic       o_timeout;
  logic [7:0] o_drop_cnt;

  logic [7:0] mem [0:127];
  logic [8:0] exp_q [$];
  int n_vec    = 0;
  int n_bad    = 0;
  int exp_drop = 0;
  int exp_tmo  = 0;
  int tmo_seen = 0;
  int rdy_mode = 0;
  bit hold_pend = 1'b0;
  bit tmo_prev  = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  rx_frame_ctrl #(.TIMEOUT_CYC(TMO), .RECOVER_CYC(REC)) dut (
    .clk(clk), .reset(reset), .i_arm(i_arm), .o_rx_enable(o_rx_enable),
    .i_rx_ev(i_rx_ev), .i_rx_ev_sig(i_rx_ev_sig), .i_rx_fcs_ok(i_rx_fcs_ok),
    .o_buf_r_addr(o_buf_r_addr), .i_buf_r_byte(i_buf_r_byte),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_drop_cnt(o_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // rx buffer model: synchronous read, data one cycle after the address
  always @(posedge clk) i_buf_r_byte <= mem[o_buf_r_addr];

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Host ready pattern: 0 always ready, 1 ready about 1 cycle in 4, 2 never ready
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(0, 3) == 0);
        default: i_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold stability, timeout pulse width
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      hold_pend = 1'b0;
      tmo_prev  = 1'b0;
    end else begin
      if (o_timeout) begin
        tmo_seen++;
        chk("timeout_width", int'(tmo_prev), 0);
      end
      tmo_prev = o_timeout;
      if (hold_pend) begin
        chk("hold_valid", int'(o_valid), 1);
        chk("hold_data", int'(o_data), int'(hold_d));
        chk("hold_last", int'(o_last), int'(hold_l));
      end
      if (o_valid) chk("rx_en_while_sending", int'(o_rx_enable), 0);
      if (o_valid && i_ready) begin
        chk("byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", int'(o_data), int'(e[7:0]));
          chk("out_last", int'(o_last), int'(e[8]));
        end
      end
      hold_pend = o_valid && !i_ready;
      hold_d    = o_data;
      hold_l    = o_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic ev(input logic [2:0] code, input bit fcs);
    i_rx_ev     = code;
    i_rx_ev_sig = 1'b1;
    i_rx_fcs_ok = fcs;
    step();
    i_rx_ev     = 3'd0;
    i_rx_ev_sig = 1'b0;
    i_rx_fcs_ok = 1'b0;
  endtask

  task automatic wait_listen();
    int b = 0;
    while (!o_rx_enable && b < 200) begin
      step();
      b++;
    end
    chk("listen_reached", int'(o_rx_enable), 1);
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() != 0 || o_valid) && b < 6000) begin
      step();
      b++;
    end
    chk("frame_drained", int'(exp_q.size() == 0 && !o_valid), 1);
  endtask

  task automatic recover_len();
    int cnt = 0;
    while (!o_rx_enable && cnt < 50) begin
      cnt++;
      step();
    end
    chk("recover_cycles", cnt, REC);
  endtask

  // One frame through the rx event stream. The reference is the buffer
  // contents 0..min(len,127) in order, with last on the final byte;
  // a bad FCS instead adds one to a saturating drop count.
  task automatic run_frame(input int len_byte, input bit fcs, input bit fill, input bit finish);
    int len;
    wait_listen();
    len = (len_byte > 127) ? 127 : len_byte;
    mem[0] = 8'(len_byte);
    if (fill) for (int i = 1; i <= len; i++) mem[i] = 8'($urandom);
    repeat ($urandom_range(0, 2)) ev(EV_PRE, 1'b0);
    ev(EV_SFD, 1'b0);
    idle($urandom_range(0, 2));
    ev(EV_PHR, 1'b0);
    for (int i = 1; i <= len; i++) begin
      idle($urandom_range(0, 1));
      ev(EV_BYTE, 1'b0);
    end
    if (fcs) begin
      for (int i = 0; i <= len; i++) exp_q.push_back({(i == len), mem[i]});
    end else begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    ev(EV_END, fcs);
    if (finish) begin
      wait_drain();
      recover_len();
      chk("drop_cnt", int'(o_drop_cnt), exp_drop);
    end
  endtask

  // Time limit
  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int b;
    reset       = 1'b1;
    i_arm       = 1'b0;
    i_rx_ev     = 3'd0;
    i_rx_ev_sig = 1'b0;
    i_rx_fcs_ok = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'd0;
    idle(3);
    chk("rst_rx_enable", int'(o_rx_enable), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_addr", int'(o_buf_r_addr), 0);
    chk("rst_drop", int'(o_drop_cnt), 0);
    reset = 1'b0;
    i_arm = 1'b1;

    // Directed good frame {03,A1,B2,C3}, then the same frame with a bad FCS
    mem[1] = 8'hA1;
    mem[2] = 8'hB2;
    mem[3] = 8'hC3;
    run_frame(3, 1'b1, 1'b0, 1'b1);
    run_frame(3, 1'b0, 1'b0, 1'b1);

    // Watchdog abort: SFD followed by silence
    wait_listen();
    ev(EV_SFD, 1'b0);
    b = 0;
    while (o_rx_enable && b < 200) begin
      step();
      b++;
    end
    chk("timeout_latency", b, int'(TMO));
    exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    exp_tmo++;
    recover_len();
    chk("timeout_pulses", tmo_seen, exp_tmo);
    chk("timeout_drop", int'(o_drop_cnt), exp_drop);

    // Sparse ready during SEND
    rdy_mode = 1;
    run_frame(8, 1'b1, 1'b1, 1'b1);

    // Random frames
    for (int k = 0; k < 20; k++) begin
      rdy_mode = $urandom_range(0, 1);
      run_frame($urandom_range(0, 20), ($urandom_range(0, 3) != 0), 1'b1, 1'b1);
    end

    // Length byte above 127 clamps to a 128-byte frame
    rdy_mode = 0;
    run_frame(200, 1'b1, 1'b1, 1'b1);

    // Disarm in RECV: back to IDLE at once, nothing counted
    wait_listen();
    ev(EV_SFD, 1'b0);
    ev(EV_PHR, 1'b0);
    ev(EV_BYTE, 1'b0);
    i_arm = 1'b0;
    step();
    chk("disarm_recv_busy", int'(o_busy), 0);
    chk("disarm_recv_rx_en", int'(o_rx_enable), 0);
    chk("disarm_recv_drop", int'(o_drop_cnt), exp_drop);
    idle(3);
    chk("disarm_stays_idle", int'(o_busy), 0);
    i_arm = 1'b1;

    // Disarm during SEND: the frame still completes, then IDLE
    rdy_mode = 1;
    run_frame(5, 1'b1, 1'b1, 1'b0);
    b = 0;
    while (!o_valid && b < 50) begin
      step();
      b++;
    end
    i_arm = 1'b0;
    wait_drain();
    chk("disarm_send_busy", int'(o_busy), 0);
    chk("disarm_send_rx_en", int'(o_rx_enable), 0);
    i_arm = 1'b1;
    rdy_mode = 0;

    // Drop counter saturation
    for (int k = 0; k < 256; k++) begin
      wait_listen();
      ev(EV_SFD, 1'b0);
      ev(EV_END, 1'b0);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    wait_listen();
    chk("drop_saturated", int'(o_drop_cnt), 255);
    chk("timeout_total", tmo_seen, exp_tmo);

    // Reset in the middle of SEND
    rdy_mode = 2;
    run_frame(5, 1'b1, 1'b1, 1'b0);
    b = 0;
    while (!o_valid && b < 50) begin
      step();
      b++;
    end
    chk("send_reached", int'(o_valid), 1);
    idle(2);
    reset = 1'b1;
    step();
    chk("midrst_rx_enable", int'(o_rx_enable), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_last", int'(o_last), 0);
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_timeout", int'(o_timeout), 0);
    chk("midrst_data", int'(o_data), 0);
    chk("midrst_addr", int'(o_buf_r_addr), 0);
    chk("midrst_drop", int'(o_drop_cnt), 0);
    reset = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    rdy_mode = 0;

    // Normal operation after the reset
    run_frame(2, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
